// File: rtl/serial_sub.sv
//------------------------------------------------------------------------------
// serial_sub -- bit-serial N-bit subtractor
//
// Computes diff = a - b - bin (modulo 2^WIDTH). The circuit handles one bit per
// clock, starting with the least significant bit. It uses a single
// full-subtractor cell and one borrow flop. A start/done handshake wraps the
// operation. The FSM has three states: IDLE -> RUN (WIDTH cycles) -> DONE
// (1 cycle) -> IDLE.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When it is defined, the module adds the ovf port (signed overflow of the
//   result) and the flops that capture the operand MSBs. When it is undefined,
//   neither the port nor that logic exists.
//
// Parameters:
//   WIDTH  operand/result width, 1..32 (default 8)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a      in   minuend, latched on the accepted start
//   b      in   subtrahend, latched on the accepted start
//   bin    in   borrow-in, latched on the accepted start
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse when diff/bout are valid
//   diff   out  difference, held until the next completion
//   bout   out  final borrow-out (1 iff a < b + bin, unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
//------------------------------------------------------------------------------
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             last;
   logic             load;
   logic             shift;
   logic             finish;

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH:0]   r_cat;
   logic [WIDTH-1:0] r_nxt;
   logic             unused_r_lsb;

   // Full-subtractor cell on the current LSBs.
   assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
   assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

   // The new bit enters the MSB of R and the oldest bit drops out of the LSB.
   // Building the shift from a concatenation keeps WIDTH=1 legal.
   assign r_cat        = {d_bit, r_sr};
   assign r_nxt        = r_cat[WIDTH:1];
   assign unused_r_lsb = r_cat[0];

   assign last = (cnt == CW'(WIDTH - 1));

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: datapath control strobes
   //---------------------------------------------------------------------------
   always_comb begin
      load   = 1'b0;
      shift  = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE: load = start;
         RUN: begin
            shift  = 1'b1;
            finish = last;
         end
         default: ;
      endcase
   end

   //---------------------------------------------------------------------------
   // Serial datapath: operand shift registers, borrow flop, bit counter
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr <= '0;
         b_sr <= '0;
         r_sr <= '0;
         br   <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         a_sr <= a;
         b_sr <= b;
         br   <= bin;
         cnt  <= '0;
      end else if (shift) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         r_sr <= r_nxt;
         br   <= br_nxt;
         cnt  <= cnt + CW'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Registered outputs. The result is updated only on DONE entry.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         if (finish) begin
            diff <= r_nxt;
            bout <= br_nxt;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;

   // Overflow: the operand signs differ and the result sign differs from the
   // minuend's sign. The result MSB is the bit produced in the last RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
         end
         if (finish) begin
            ovf <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
         end
      end
   end
`endif

endmodule
